td4_prog_loader: RTL and testbench

- Program memory that feeds the TD4 core: returns the 8-bit instruction (op[7:4], im[3:0]) for the core's 4-bit fetch address.
- Loaded at runtime through a single-clock serial interface; holds the core in reset while loading.
- Releases the core into RUN when a complete image has been written, or on explicit request.
- Sits directly upstream of the CPU core: drives its data bus and its active-low reset.

---
 rtl/td4_prog_loader.sv | 141 ++++++++++++++
 tb/tb_td4_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// Serially loaded program memory for the TD4 core: combinational fetch port,
// holds the core in reset while a new image is shifted in MSB first.
module td4_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addres,
  output logic [DATA_W-1:0] data,
  input  logic              ld_en,
  input  logic              run_req,
  input  logic              ser_valid,
  input  logic              ser_in,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_cnt,
  output logic [DATA_W-1:0] csum
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BC_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     prog_cnt_q, prog_cnt_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                load_err_q, load_err_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr_en;
  logic [DATA_W-1:0]   wr_word;

  assign data      = mem_q[addres];
  assign cpu_rst_n = (state_q == S_RUN);
  assign load_busy = (state_q == S_LOAD);
  assign load_err  = load_err_q;
  assign prog_cnt  = prog_cnt_q;
  assign csum      = csum_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    prog_cnt_d = prog_cnt_q;
    csum_d     = csum_q;
    load_err_d = load_err_q;
    // A new load from RUN needs ld_en to have been seen low since the last completion.
    armed_d    = armed_q | ~ld_en;
    wr_en      = 1'b0;
    wr_word    = {shift_q[DATA_W-2:0], ser_in};

    case (state_q)
      S_IDLE: begin
        if (ld_en) begin
          state_d = S_LOAD;
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (!ld_en) begin
          state_d    = S_IDLE;
          load_err_d = 1'b1;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end else if (ser_valid) begin
          shift_d = wr_word;
          if (bit_cnt_q == BC_W'(DATA_W-1)) begin
            bit_cnt_d  = '0;
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            prog_cnt_d = prog_cnt_q + (ADDR_W+1)'(1);
            csum_d     = csum_q + wr_word;
            if (wr_ptr_q == ADDR_W'(DEPTH-1)) begin
              state_d = S_RUN;
              armed_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      S_RUN: begin
        if (ld_en && armed_q) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD && state_q != S_LOAD) begin
      shift_d    = '0;
      bit_cnt_d  = '0;
      wr_ptr_d   = '0;
      prog_cnt_d = '0;
      csum_d     = '0;
      load_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      prog_cnt_q <= '0;
      csum_q     <= '0;
      load_err_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_cnt_q <= prog_cnt_d;
      csum_q     <= csum_d;
      load_err_q <= load_err_d;
      armed_q    <= armed_d;
    end
  end

  // Reset image is all 0x00, which the core executes as a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Scoreboard bench for td4_prog_loader: queued expected words are checked on
// the fetch port as each byte lands, plus control/status checks per scenario.
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] addres = '0;
  logic [7:0] data;
  logic       ld_en = 1'b0;
  logic       run_req = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_in = 1'b0;
  logic       cpu_rst_n;
  logic       load_busy;
  logic       load_err;
  logic [4:0] prog_cnt;
  logic [7:0] csum;

  td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .addres(addres), .data(data),
    .ld_en(ld_en), .run_req(run_req), .ser_valid(ser_valid), .ser_in(ser_in),
    .cpu_rst_n(cpu_rst_n), .load_busy(load_busy), .load_err(load_err),
    .prog_cnt(prog_cnt), .csum(csum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] w;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [16];
  int         wptr;
  logic [7:0] sum;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at a falling edge; the strobe spans exactly one rising edge.
  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    @(negedge clk);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] w, input bit last);
    exp_t e;
    sb_q.push_back({4'(wptr), w});
    model[wptr] = w;
    wptr++;
    sum = sum + w;
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 0 && last) chk("rst_n_before_final_bit", cpu_rst_n, 0);
      send_bit(w[i]);
    end
    e = sb_q.pop_front();
    addres = e.a;
    #1;
    chk("written_word", data, e.w);
    @(negedge clk);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      addres = 4'(a);
      #1;
      chk(tag, data, model[a]);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    wptr = 0;
    sum  = 8'h00;

    // 1. reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_cpu_rst_n", cpu_rst_n, 0);
    chk("reset_load_busy", load_busy, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_prog_cnt", prog_cnt, 0);
    chk("reset_csum", csum, 8'h00);
    sweep("reset_mem");

    // 2. full load 0x30..0x3F
    ld_en = 1'b1;
    @(negedge clk);
    chk("load_busy_entry", load_busy, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), i == 15);
    chk("full_cpu_rst_n", cpu_rst_n, 1);
    chk("full_prog_cnt", prog_cnt, 16);
    chk("full_csum", csum, 8'h78);
    chk("full_load_busy", load_busy, 0);
    chk("full_load_err", load_err, 0);
    sweep("full_mem");

    // 3. aborted load: 5 x 0xB1 plus 3 bits
    ld_en = 1'b0;
    @(negedge clk);
    ld_en = 1'b1;
    @(negedge clk);
    chk("reload_busy", load_busy, 1);
    chk("reload_prog_cnt", prog_cnt, 0);
    wptr = 0;
    sum  = 8'h00;
    for (int i = 0; i < 5; i++) send_byte(8'hB1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ld_en = 1'b0;
    @(negedge clk);
    chk("abort_load_busy", load_busy, 0);
    chk("abort_load_err", load_err, 1);
    chk("abort_prog_cnt", prog_cnt, 5);
    chk("abort_csum", csum, 8'h75);
    chk("abort_cpu_rst_n", cpu_rst_n, 0);
    sweep("abort_mem");

    // 4. run from IDLE
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    chk("idle_run_cpu_rst_n", cpu_rst_n, 1);
    chk("idle_run_load_err", load_err, 1);
    sweep("idle_run_mem");

    // 5. reload from RUN, ld_en held through completion, then re-arm
    ld_en = 1'b1;
    @(negedge clk);
    chk("run_reload_busy", load_busy, 1);
    chk("run_reload_err_clr", load_err, 0);
    chk("run_reload_csum", csum, 8'h00);
    chk("run_reload_cpu_rst_n", cpu_rst_n, 0);
    wptr = 0;
    sum  = 8'h00;
    for (int i = 0; i < 16; i++) send_byte(8'(8'hC3 + i * 13), i == 15);
    repeat (3) @(negedge clk);
    chk("held_stays_run", cpu_rst_n, 1);
    chk("held_not_busy", load_busy, 0);
    chk("held_prog_cnt", prog_cnt, 16);
    chk("held_csum", csum, sum);
    sweep("held_mem");
    ld_en = 1'b0;
    @(negedge clk);
    chk("rearm_low_run", cpu_rst_n, 1);
    ld_en = 1'b1;
    @(negedge clk);
    chk("rearm_busy", load_busy, 1);
    chk("rearm_cpu_rst_n", cpu_rst_n, 0);
    chk("rearm_load_err", load_err, 0);
    chk("rearm_csum", csum, 8'h00);

    // 6. async reset mid-byte
    wptr = 0;
    sum  = 8'h00;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    addres = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    chk("async_cpu_rst_n", cpu_rst_n, 0);
    chk("async_load_busy", load_busy, 0);
    chk("async_prog_cnt", prog_cnt, 0);
    chk("async_csum", csum, 8'h00);
    chk("async_load_err", load_err, 0);
    chk("async_data", data, 8'h00);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    sb_q.delete();
    wptr = 0;
    sum  = 8'h00;
    ld_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep("post_rst_mem");

    // simultaneous ld_en, run_req and ser_valid in IDLE
    ld_en     = 1'b1;
    run_req   = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    run_req   = 1'b0;
    chk("simul_load_busy", load_busy, 1);
    chk("simul_cpu_rst_n", cpu_rst_n, 0);
    chk("simul_prog_cnt", prog_cnt, 0);
    send_byte(8'h5A, 1'b0);
    chk("simul_byte_prog_cnt", prog_cnt, 1);
    chk("simul_byte_csum", csum, 8'h5A);
    ld_en = 1'b0;
    @(negedge clk);
    chk("simul_abort_err", load_err, 1);
    sweep("simul_mem");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
